// File: rtl/rtc_bus_writer.sv
// Multiplexed-bus RTC write sequencer: address phase then data phase, each
// with setup/strobe/hold timing; all state and outputs update on the falling edge.
module rtc_bus_writer #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] ADDR,
    input  logic [7:0] DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       CS_N,
    output logic       WR_N,
    output logic       RD_N,
    output logic       A_D,
    output logic [7:0] AD_OUT,
    output logic       AD_OE
);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, FIN
    } state_t;

    localparam logic [3:0] LD_S = 4'(T_SETUP - 1);
    localparam logic [3:0] LD_P = 4'(T_PULSE - 1);
    localparam logic [3:0] LD_H = 4'(T_HOLD - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] addr_q, data_q, addr_nxt, data_nxt;

    logic       a_ph, d_ph, strobe;
    logic [7:0] ad_out_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = A_SETUP;
                    cnt_nxt   = LD_S;
                    addr_nxt  = ADDR;
                    data_nxt  = DATA;
                end
            end
            FIN: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    // reload the shared counter with the length of the state being entered
                    case (state)
                        A_SETUP:  begin state_nxt = A_STROBE; cnt_nxt = LD_P; end
                        A_STROBE: begin state_nxt = A_HOLD;   cnt_nxt = LD_H; end
                        A_HOLD:   begin state_nxt = D_SETUP;  cnt_nxt = LD_S; end
                        D_SETUP:  begin state_nxt = D_STROBE; cnt_nxt = LD_P; end
                        D_STROBE: begin state_nxt = D_HOLD;   cnt_nxt = LD_H; end
                        default:  begin state_nxt = FIN;      cnt_nxt = 4'd0; end
                    endcase
                end
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they describe.
    always_comb begin
        a_ph   = (state_nxt == A_SETUP) || (state_nxt == A_STROBE) || (state_nxt == A_HOLD);
        d_ph   = (state_nxt == D_SETUP) || (state_nxt == D_STROBE) || (state_nxt == D_HOLD);
        strobe = (state_nxt == A_STROBE) || (state_nxt == D_STROBE);
        ad_out_nxt = 8'h00;
        if (a_ph)      ad_out_nxt = addr_nxt;
        else if (d_ph) ad_out_nxt = data_nxt;
    end

    always_ff @(negedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= 8'h00;
            data_q <= 8'h00;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            CS_N   <= 1'b1;
            WR_N   <= 1'b1;
            A_D    <= 1'b0;
            AD_OUT <= 8'h00;
            AD_OE  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            BUSY   <= (state_nxt != IDLE);
            DONE   <= (state_nxt == FIN);
            CS_N   <= ~strobe;
            WR_N   <= ~strobe;
            A_D    <= d_ph;
            AD_OUT <= ad_out_nxt;
            AD_OE  <= a_ph | d_ph;
        end
    end

    assign RD_N = 1'b1;

endmodule
